// File: rtl/pong_event_gen.sv
// Frame-synchronous Pong event detector: wall/paddle/goal pulses, scores, serve hold-off
// and game-end level. All outputs registered, one cycle after the causing frame_tick.
module pong_event_gen #(
  parameter int unsigned SCREEN_W     = 640,
  parameter int unsigned SCREEN_H     = 480,
  parameter int unsigned BALL_SIZE    = 8,
  parameter int unsigned PADDLE_W     = 8,
  parameter int unsigned PADDLE_H     = 64,
  parameter int unsigned PADDLE_LX    = 16,
  parameter int unsigned PADDLE_RX    = 616,
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SERVE_FRAMES = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic [9:0] ball_x,
  input  logic [9:0] ball_y,
  input  logic [9:0] paddle_l_y,
  input  logic [9:0] paddle_r_y,
  output logic       wall_hit,
  output logic       paddle_hit,
  output logic       point_l,
  output logic       point_r,
  output logic       serve,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_end
);

  localparam logic [10:0] ScrW   = 11'(SCREEN_W);
  localparam logic [10:0] ScrH   = 11'(SCREEN_H);
  localparam logic [10:0] BallSz = 11'(BALL_SIZE);
  localparam logic [10:0] PadW   = 11'(PADDLE_W);
  localparam logic [10:0] PadH   = 11'(PADDLE_H);
  localparam logic [10:0] PadLx  = 11'(PADDLE_LX);
  localparam logic [10:0] PadRx  = 11'(PADDLE_RX);
  localparam logic [3:0]  Win    = 4'(WIN_SCORE);
  localparam logic [7:0]  SrvCnt = 8'(SERVE_FRAMES - 1);

  typedef enum logic [1:0] {StPlay, StServe, StOver} state_e;

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] score_l_q, score_l_d, score_r_q, score_r_d;
  logic       wall_prev_q, wall_prev_d, pad_prev_q, pad_prev_d;
  logic       wall_hit_d, paddle_hit_d, point_l_d, point_r_d, serve_d;

  // 11-bit geometry so that position + size never wraps
  logic [10:0] bx, by, bx_end, by_end, pl, pr;
  logic [3:0]  score_l_inc, score_r_inc;
  logic        wall, pad_l, pad_r, pad, goal_l, goal_r;

  assign bx     = {1'b0, ball_x};
  assign by     = {1'b0, ball_y};
  assign bx_end = bx + BallSz;
  assign by_end = by + BallSz;
  assign pl     = {1'b0, paddle_l_y};
  assign pr     = {1'b0, paddle_r_y};

  assign wall   = (ball_y == 10'd0) || (by_end >= ScrH);
  assign pad_l  = (bx < PadLx + PadW) && (bx_end > PadLx) && (by_end > pl) && (by < pl + PadH);
  assign pad_r  = (bx < PadRx + PadW) && (bx_end > PadRx) && (by_end > pr) && (by < pr + PadH);
  assign pad    = pad_l || pad_r;
  assign goal_r = (ball_x == 10'd0);
  assign goal_l = (bx_end >= ScrW);

  assign score_l_inc = (score_l_q == 4'hf) ? 4'hf : score_l_q + 4'd1;
  assign score_r_inc = (score_r_q == 4'hf) ? 4'hf : score_r_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    wall_prev_d  = wall_prev_q;
    pad_prev_d   = pad_prev_q;
    wall_hit_d   = 1'b0;
    paddle_hit_d = 1'b0;
    point_l_d    = 1'b0;
    point_r_d    = 1'b0;
    serve_d      = 1'b0;
    if (frame_tick) begin
      unique case (state_q)
        StPlay: begin
          wall_prev_d = wall;
          pad_prev_d  = pad;
          if (goal_r) begin
            point_r_d = 1'b1;
            score_r_d = score_r_inc;
            if (score_r_inc == Win) begin
              state_d = StOver;
            end else begin
              state_d = StServe;
              cnt_d   = SrvCnt;
            end
          end else if (goal_l) begin
            point_l_d = 1'b1;
            score_l_d = score_l_inc;
            if (score_l_inc == Win) begin
              state_d = StOver;
            end else begin
              state_d = StServe;
              cnt_d   = SrvCnt;
            end
          end else begin
            wall_hit_d   = wall && !wall_prev_q;
            paddle_hit_d = pad && !pad_prev_q;
          end
        end
        StServe: begin
          wall_prev_d = 1'b0;
          pad_prev_d  = 1'b0;
          if (cnt_q == 8'd0) begin
            serve_d = 1'b1;
            state_d = StPlay;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        StOver: ;
        default: state_d = StPlay;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StPlay;
      cnt_q       <= 8'd0;
      score_l_q   <= 4'd0;
      score_r_q   <= 4'd0;
      wall_prev_q <= 1'b0;
      pad_prev_q  <= 1'b0;
      wall_hit    <= 1'b0;
      paddle_hit  <= 1'b0;
      point_l     <= 1'b0;
      point_r     <= 1'b0;
      serve       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
      wall_prev_q <= wall_prev_d;
      pad_prev_q  <= pad_prev_d;
      wall_hit    <= wall_hit_d;
      paddle_hit  <= paddle_hit_d;
      point_l     <= point_l_d;
      point_r     <= point_r_d;
      serve       <= serve_d;
    end
  end

  assign score_l  = score_l_q;
  assign score_r  = score_r_q;
  assign game_end = (state_q == StOver);

endmodule
